pos_equiv_sweeper: RTL and testbench
====================================

// Module: pos_equiv_sweeper
// PURPOSE
//  Self-timed stimulus/checker stage around the Guia 06 reduced-vs-canonical function bank.
//  Drives the shared x,y,z inputs through every minterm, one function pair at a time via func_sel.
//  Samples each pair's reduced output (s) and canonical POS output (control), then reports mismatches.
//  Sits upstream of the a..e modules (feeds x,y,z) and downstream of them (consumes s, control).
// PARAMETERS
//  N_FUNC   5  number of function pairs swept; func_sel counts 0..N_FUNC-1
//  N_VARS   3  number of input variables; vec counts 0..2**N_VARS-1; x=vec[2], y=vec[1], z=vec[0] at default
//  SETTLE   1  cycles each vector is held before sampling; legal range >=1
// PORTS
//  clk            in   1          single clock; all state updates on posedge
//  rst_n          in   1          asynchronous, active-low reset
//  start          in   1          begin a sweep; accepted only in IDLE
//  s_in           in   1          reduced output of the selected pair (external mux on func_sel)
//  ctrl_in        in   1          canonical output of the selected pair
//  vec            out  N_VARS     current input vector driven onto x,y,z (MSB = x)
//  func_sel       out  3          index of the pair under test
//  busy           out  1          high from start acceptance until DONE is exited
//  done           out  1          one-cycle pulse at sweep end
//  err_valid      out  1          one-cycle pulse on each sampled mismatch
//  err_func       out  3          func_sel of the last mismatch; held
//  err_idx        out  N_VARS     vec of the last mismatch; held
//  mismatch_count out  8          total mismatches in the sweep; saturates at 255
//  fail_mask      out  N_FUNC     bit f set if pair f mismatched at least once
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; every output = 0; wait counter = 0.
//  States:
//   IDLE  -> DRIVE on start=1: vec=0, func_sel=0, wait=SETTLE-1.
//            mismatch_count, fail_mask, err_func and err_idx clear on that same edge.
//   DRIVE -> hold vec/func_sel; decrement wait; go to CHECK when wait==0.
//            DRIVE lasts exactly SETTLE cycles.
//   CHECK -> one cycle; sample s_in, ctrl_in on its closing edge.
//            Mismatch (s_in!=ctrl_in): err_valid=1 for the next cycle, err_func/err_idx <= current,
//            fail_mask[func_sel]<=1, mismatch_count+=1 unless already 255.
//            Advance: if vec!=max, vec+=1; else vec=0 and func_sel+=1.
//            If last vec of last pair, go to DONE; otherwise go to DRIVE with wait=SETTLE-1.
//   DONE  -> done=1 for exactly one cycle, busy still 1; then IDLE with busy=0.
//  Timing:
//   Latency per vector is SETTLE+1 cycles.
//   Sweep length is N_FUNC*2**N_VARS*(SETTLE+1) cycles from the start edge to the DONE entry edge.
//   That is 80 cycles at the defaults.
//  Outputs and results:
//   vec/func_sel change only on the CHECK->DRIVE edge, so they are glitch-free for the settle window.
//   Results (count, mask, err_*) hold after DONE until the next accepted start.
//  Boundary cases:
//   start while busy: ignored, no restart, no clear.
//   start held high: a new sweep begins on the first IDLE cycle.
//   rst_n asserted mid-sweep: immediate return to IDLE with all outputs 0; no done pulse.
//   Last vector mismatch: err_valid and done are asserted in the same cycle.
//   Saturation: mismatch_count stays at 255; fail_mask and err_* still update.
// STRUCTURE
//  Shared package guia06_pkg:
//   state encoding ST_IDLE/ST_DRIVE/ST_CHECK/ST_DONE (2-bit)
//   CNT_W=8 and CNT_MAX=8'hFF
//  Natural sub-module: pos_vec_counter.
//   Holds the vec/func_sel nested counter.
//   Inputs: clk, rst_n, clr, adv.
//   Output: last (high on the final vec of the final pair).
//  The FSM, settle timer and result registers stay in the top.
// TESTING
//  1. Bench wires a..e, start pulse at defaults -> done at cycle 80, mismatch_count=0, fail_mask=5'b00000.
//  2. Force ctrl_in inverted only when func_sel=2, vec=3'b101
//     -> single err_valid, err_func=2, err_idx=5, count=1, mask=5'b00100.
//  3. s_in stuck 0, ctrl_in=reference pair a -> count equals number of 1s of pair a (5), mask bit0 set.
//  4. rst_n low at cycle 30 -> all outputs 0 asynchronously, no done; a new start gives a clean 80-cycle sweep.
//  5. start pulsed again at cycle 20 while busy -> ignored; done still at cycle 80 of the first sweep.
//  6. N_VARS=6, SETTLE=2, s_in=~ctrl_in always
//     -> count saturates at 255, mask all 1s, done at 5*64*3=960 cycles.

Source files
------------

// File: rtl/guia06_pkg.sv
// Shared types and constants for the reduced-vs-canonical function bank sweeper.
package guia06_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int unsigned CNT_W  = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;
    localparam int unsigned FSEL_W = 3;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pos_equiv_sweeper_if.sv
// Stimulus/result bundle between the sweeper and the function bank under test.
interface pos_equiv_sweeper_if
    import guia06_pkg::*;
#(
    parameter int unsigned N_FUNC = 5,
    parameter int unsigned N_VARS = 3
);
    logic              start;
    logic              s_in;
    logic              ctrl_in;
    logic [N_VARS-1:0] vec;
    logic [FSEL_W-1:0] func_sel;
    logic              busy;
    logic              done;
    logic              err_valid;
    logic [FSEL_W-1:0] err_func;
    logic [N_VARS-1:0] err_idx;
    logic [CNT_W-1:0]  mismatch_count;
    logic [N_FUNC-1:0] fail_mask;

    modport master (
        output start, s_in, ctrl_in,
        input  vec, func_sel, busy, done, err_valid, err_func, err_idx, mismatch_count,
               fail_mask
    );

    modport slave (
        input  start, s_in, ctrl_in,
        output vec, func_sel, busy, done, err_valid, err_func, err_idx, mismatch_count,
               fail_mask
    );
endinterface

// File: rtl/pos_vec_counter.sv
// Nested vector/function-pair counter; vec wraps into a func_sel increment.
module pos_vec_counter
    import guia06_pkg::*;
#(
    parameter int unsigned N_FUNC = 5,
    parameter int unsigned N_VARS = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              adv,
    output logic [N_VARS-1:0] vec,
    output logic [FSEL_W-1:0] func_sel,
    output logic              last
);
    localparam logic [N_VARS-1:0] VEC_MAX   = '1;
    localparam logic [FSEL_W-1:0] FUNC_LAST = FSEL_W'(N_FUNC - 1);

    logic [N_VARS-1:0] vec_q;
    logic [FSEL_W-1:0] func_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q  <= '0;
            func_q <= '0;
        end else if (clr) begin
            vec_q  <= '0;
            func_q <= '0;
        end else if (adv) begin
            if (vec_q == VEC_MAX) begin
                vec_q  <= '0;
                func_q <= func_q + 3'd1;
            end else begin
                vec_q <= vec_q + 1'b1;
            end
        end
    end

    assign vec      = vec_q;
    assign func_sel = func_q;
    assign last     = (vec_q == VEC_MAX) && (func_q == FUNC_LAST);
endmodule

// File: rtl/pos_equiv_sweeper.sv
// Sweeps every minterm of each function pair and records reduced/canonical mismatches.
module pos_equiv_sweeper
    import guia06_pkg::*;
#(
    parameter int unsigned N_FUNC = 5,
    parameter int unsigned N_VARS = 3,
    parameter int unsigned SETTLE = 1
) (
    input logic                clk,
    input logic                rst_n,
    pos_equiv_sweeper_if.slave bus
);
    localparam int unsigned WAIT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(SETTLE - 1);
    localparam logic [N_FUNC-1:0] MASK_ONE  = N_FUNC'(1);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_valid_q, err_valid_d;
    logic [FSEL_W-1:0] err_func_q, err_func_d;
    logic [N_VARS-1:0] err_idx_q, err_idx_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [N_FUNC-1:0] mask_q, mask_d;

    logic              clr;
    logic              adv;
    logic              last;
    logic [N_VARS-1:0] vec;
    logic [FSEL_W-1:0] func_sel;

    pos_vec_counter #(
        .N_FUNC (N_FUNC),
        .N_VARS (N_VARS)
    ) u_vec_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .adv      (adv),
        .vec      (vec),
        .func_sel (func_sel),
        .last     (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wait_q      <= '0;
            err_valid_q <= 1'b0;
            err_func_q  <= '0;
            err_idx_q   <= '0;
            count_q     <= '0;
            mask_q      <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            err_valid_q <= err_valid_d;
            err_func_q  <= err_func_d;
            err_idx_q   <= err_idx_d;
            count_q     <= count_d;
            mask_q      <= mask_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        err_valid_d = 1'b0;
        err_func_d  = err_func_q;
        err_idx_d   = err_idx_q;
        count_d     = count_q;
        mask_d      = mask_q;
        clr         = 1'b0;
        adv         = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d    = ST_DRIVE;
                    wait_d     = WAIT_LOAD;
                    clr        = 1'b1;
                    count_d    = '0;
                    mask_d     = '0;
                    err_func_d = '0;
                    err_idx_d  = '0;
                end
            end
            ST_DRIVE: begin
                if (wait_q == '0) begin
                    state_d = ST_CHECK;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            ST_CHECK: begin
                if (bus.s_in != bus.ctrl_in) begin
                    err_valid_d = 1'b1;
                    err_func_d  = func_sel;
                    err_idx_d   = vec;
                    mask_d      = mask_q | (MASK_ONE << func_sel);
                    count_d     = sat_inc(count_q);
                end
                // Vector only moves here so x,y,z stay stable for the whole settle window.
                adv = 1'b1;
                if (last) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRIVE;
                    wait_d  = WAIT_LOAD;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.vec            = vec;
    assign bus.func_sel       = func_sel;
    assign bus.busy           = (state_q != ST_IDLE);
    assign bus.done           = (state_q == ST_DONE);
    assign bus.err_valid      = err_valid_q;
    assign bus.err_func       = err_func_q;
    assign bus.err_idx        = err_idx_q;
    assign bus.mismatch_count = count_q;
    assign bus.fail_mask      = mask_q;
endmodule

// File: tb/tb_pos_equiv_sweeper.sv
// Directed + randomized bench: a truth-table function bank with injectable flips feeds the sweeper.
module tb_pos_equiv_sweeper;
    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    pos_equiv_sweeper_if #(.N_FUNC(5), .N_VARS(3)) bus ();
    pos_equiv_sweeper_if #(.N_FUNC(5), .N_VARS(6)) bus6 ();

    pos_equiv_sweeper #(.N_FUNC(5), .N_VARS(3), .SETTLE(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    pos_equiv_sweeper #(.N_FUNC(5), .N_VARS(6), .SETTLE(2)) dut6 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference truth tables for pairs a..e, indexed by minterm {x,y,z}; pair a has five 1s.
    logic [7:0] tt [5] = '{8'b1110_1010, 8'b1001_0110, 8'b0111_1000, 8'b0011_0011, 8'b1100_0001};
    // A set flip bit makes the reduced output disagree with the canonical one at that minterm.
    logic [7:0] flip [5];

    always_comb begin
        bus.ctrl_in = 1'b0;
        bus.s_in    = 1'b0;
        if (int'(bus.func_sel) < 5) begin
            bus.ctrl_in = tt[int'(bus.func_sel)][bus.vec];
            bus.s_in    = bus.ctrl_in ^ flip[int'(bus.func_sel)][bus.vec];
        end
    end

    always_comb begin
        bus6.ctrl_in = ^bus6.vec;
        bus6.s_in    = ~bus6.ctrl_in;
    end

    int ev_cnt = 0;
    int dn_cnt = 0;
    always @(negedge clk) begin
        ev_cnt <= ev_cnt + int'(bus.err_valid);
        dn_cnt <= dn_cnt + int'(bus.done);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected sweep results straight from the flip table, in sweep order.
    task automatic model(output int cnt, output logic [4:0] mask, output int ef, output int ei,
                         output int nerr);
        cnt = 0; mask = '0; ef = 0; ei = 0; nerr = 0;
        for (int f = 0; f < 5; f++) begin
            for (int v = 0; v < 8; v++) begin
                if (flip[f][v]) begin
                    nerr++;
                    if (cnt < 255) cnt++;
                    mask[f] = 1'b1;
                    ef = f;
                    ei = v;
                end
            end
        end
    endtask

    task automatic zero_check(input string tag);
        check({tag, "_busy"}, 32'(bus.busy), 0);
        check({tag, "_done"}, 32'(bus.done), 0);
        check({tag, "_vec"}, 32'(bus.vec), 0);
        check({tag, "_fsel"}, 32'(bus.func_sel), 0);
        check({tag, "_ev"}, 32'(bus.err_valid), 0);
        check({tag, "_cnt"}, 32'(bus.mismatch_count), 0);
        check({tag, "_mask"}, 32'(bus.fail_mask), 0);
        check({tag, "_efunc"}, 32'(bus.err_func), 0);
        check({tag, "_eidx"}, 32'(bus.err_idx), 0);
    endtask

    // Waits for done (bounded) counting edges after the start edge; restart_at injects a start.
    task automatic sweep(input string tag, input int restart_at);
        int k, cnt, ef, ei, nerr, ev0;
        logic [4:0] mask;
        model(cnt, mask, ef, ei, nerr);
        @(negedge clk);
        ev0 = ev_cnt;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, "_busy_run"}, 32'(bus.busy), 1);
        k = 0;
        while (!bus.done && k < 300) begin
            bus.start = (k == restart_at);
            @(negedge clk);
            k++;
        end
        bus.start = 1'b0;
        check({tag, "_latency"}, k, 80);
        check({tag, "_cnt"}, 32'(bus.mismatch_count), cnt);
        check({tag, "_mask"}, 32'(bus.fail_mask), 32'(mask));
        check({tag, "_efunc"}, 32'(bus.err_func), ef);
        check({tag, "_eidx"}, 32'(bus.err_idx), ei);
        check({tag, "_last_ev"}, 32'(bus.err_valid), 32'(flip[4][7]));
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(bus.done), 0);
        check({tag, "_idle"}, 32'(bus.busy), 0);
        check({tag, "_ev_pulses"}, ev_cnt - ev0, nerr);
        check({tag, "_hold_cnt"}, 32'(bus.mismatch_count), cnt);
    endtask

    initial begin
        int dn0, k;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus6.start = 1'b0;
        for (int f = 0; f < 5; f++) flip[f] = '0;
        #3;
        zero_check("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Clean bank: no mismatches anywhere.
        sweep("clean", -1);

        // Single injected fault at pair 2, minterm 5.
        flip[2] = 8'b0010_0000;
        sweep("inject", -1);
        check("inject_spec_cnt", 32'(bus.mismatch_count), 1);
        check("inject_spec_mask", 32'(bus.fail_mask), 32'b00100);
        check("inject_spec_idx", 32'(bus.err_idx), 5);

        // Reduced output of pair a stuck at 0.
        flip[2] = '0;
        flip[0] = tt[0];
        sweep("stuck0", -1);
        check("stuck0_spec_cnt", 32'(bus.mismatch_count), 5);

        // Mismatch on the very last vector coincides with done.
        flip[0] = '0;
        flip[4] = 8'b1000_0000;
        sweep("lastvec", -1);

        // Start while busy is ignored: no restart and no clearing of the early error.
        flip[4] = '0;
        flip[0] = 8'b0000_0001;
        sweep("restart", 20);

        // Randomized fault patterns against the model.
        for (int r = 0; r < 3; r++) begin
            for (int f = 0; f < 5; f++) flip[f] = 8'($urandom) & 8'($urandom);
            sweep($sformatf("rand%0d", r), -1);
        end

        // Asynchronous reset mid-sweep.
        for (int f = 0; f < 5; f++) flip[f] = '0;
        flip[0] = 8'b0000_0010;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 29; i++) @(negedge clk);
        check("midrst_pre_cnt", 32'(bus.mismatch_count), 1);
        dn0 = dn_cnt;
        #1 rst_n = 1'b0;
        #1 zero_check("midrst");
        repeat (3) @(negedge clk);
        check("midrst_no_done", dn_cnt - dn0, 0);
        rst_n = 1'b1;
        flip[0] = '0;
        sweep("after_rst", -1);

        // Wide variant: every sample mismatches, count saturates.
        @(negedge clk);
        bus6.start = 1'b1;
        @(negedge clk);
        bus6.start = 1'b0;
        k = 0;
        while (!bus6.done && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("wide_latency", k, 960);
        check("wide_cnt", 32'(bus6.mismatch_count), 255);
        check("wide_mask", 32'(bus6.fail_mask), 32'b11111);
        check("wide_efunc", 32'(bus6.err_func), 4);
        check("wide_eidx", 32'(bus6.err_idx), 63);
        check("wide_last_ev", 32'(bus6.err_valid), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
